// File: rtl/hex_disp_pkg.sv
//------------------------------------------------------------------------------
// Module  : hex_disp_pkg
// Brief   : Register map, CTRL bit positions and display constants shared by
//           the multi-digit seven-segment display block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package hex_disp_pkg;

    localparam logic [3:0] c_addr_ctrl   = 4'd8;
    localparam logic [3:0] c_addr_blank  = 4'd9;
    localparam logic [3:0] c_addr_packed = 4'd10;
    localparam logic [3:0] c_addr_status = 4'd11;

    localparam int c_ctrl_mode_bit  = 0;
    localparam int c_ctrl_blink_bit = 1;

    localparam logic [6:0] c_seg_blank = 7'h7F;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_RAW = 1'b1
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
//------------------------------------------------------------------------------
// Module  : hex7seg
// Brief   : Combinational 0-F glyph lookup, active-low, bit 0 = segment a.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multi_hex_display.sv
//------------------------------------------------------------------------------
// Module  : multi_hex_display
// Brief   : Avalon-MM slave driving NUM_DIGITS seven-segment digits with hex or
//           raw mode, per-digit blanking and a global blink.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_hex_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [7*NUM_DIGITS-1:0] hex_export
);

    import hex_disp_pkg::*;

    localparam int c_cnt_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [6:0]              r_digit_q [NUM_DIGITS];
    logic [6:0]              w_digit_d [NUM_DIGITS];
    logic [1:0]              r_ctrl_q,  w_ctrl_d;
    logic [NUM_DIGITS-1:0]   r_blank_q, w_blank_d;
    logic [c_cnt_w-1:0]      r_cnt_q,   w_cnt_d;
    logic                    r_phase_q, w_phase_d;
    logic [31:0]             r_rdata_q, w_rdata_d;
    logic [7*NUM_DIGITS-1:0] r_hex_q,   w_hex_d;
    logic [6:0]              w_glyph [NUM_DIGITS];
    logic                    w_blink_run;
    logic                    w_blank_all;
    mode_e                   w_mode;
    logic                    w_unused_wdata;

    assign w_unused_wdata = ^avs_writedata;

    always_comb begin
        w_digit_d = r_digit_q;
        w_ctrl_d  = r_ctrl_q;
        w_blank_d = r_blank_q;
        if (avs_write) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (avs_address == 4'(i)) begin
                    w_digit_d[i] = avs_writedata[6:0];
                end
            end
            case (avs_address)
                c_addr_ctrl:   w_ctrl_d  = avs_writedata[1:0];
                c_addr_blank:  w_blank_d = avs_writedata[NUM_DIGITS-1:0];
                c_addr_packed: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        w_digit_d[i] = {3'b000, avs_writedata[4*i +: 4]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Counting starts the cycle after blink_en is set; clearing it zeroes the
    // phase in the same cycle so digits return without a blanked frame.
    always_comb begin
        w_blink_run = r_ctrl_q[c_ctrl_blink_bit] & w_ctrl_d[c_ctrl_blink_bit];
        w_cnt_d     = '0;
        w_phase_d   = 1'b0;
        if (w_blink_run) begin
            if (r_cnt_q == c_cnt_w'(BLINK_DIV - 1)) begin
                w_cnt_d   = '0;
                w_phase_d = ~r_phase_q;
            end else begin
                w_cnt_d   = r_cnt_q + c_cnt_w'(1);
                w_phase_d = r_phase_q;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            hex7seg u_hex7seg (
                .i_nibble (w_digit_d[gi][3:0]),
                .o_seg    (w_glyph[gi])
            );
        end
    endgenerate

    // Built from next-state values so a write lands on the pins one cycle later.
    always_comb begin
        w_mode      = mode_e'(w_ctrl_d[c_ctrl_mode_bit]);
        w_blank_all = w_ctrl_d[c_ctrl_blink_bit] & w_phase_d;
        w_hex_d     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_blank_all || w_blank_d[i]) begin
                w_hex_d[7*i +: 7] = c_seg_blank;
            end else if (w_mode == MODE_RAW) begin
                w_hex_d[7*i +: 7] = ~w_digit_d[i];
            end else begin
                w_hex_d[7*i +: 7] = w_glyph[i];
            end
        end
    end

    always_comb begin
        w_rdata_d = r_rdata_q;
        if (avs_read) begin
            w_rdata_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (avs_address == 4'(i)) begin
                    w_rdata_d = {25'd0, r_digit_q[i]};
                end
            end
            case (avs_address)
                c_addr_ctrl:   w_rdata_d = {30'd0, r_ctrl_q};
                c_addr_blank:  w_rdata_d = 32'(r_blank_q);
                c_addr_status: w_rdata_d = {31'd0, r_phase_q};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit_q[i] <= '0;
            end
            r_ctrl_q  <= '0;
            r_blank_q <= '1;
            r_cnt_q   <= '0;
            r_phase_q <= 1'b0;
            r_rdata_q <= '0;
            r_hex_q   <= '1;
        end else begin
            r_digit_q <= w_digit_d;
            r_ctrl_q  <= w_ctrl_d;
            r_blank_q <= w_blank_d;
            r_cnt_q   <= w_cnt_d;
            r_phase_q <= w_phase_d;
            r_rdata_q <= w_rdata_d;
            r_hex_q   <= w_hex_d;
        end
    end

    assign avs_readdata = r_rdata_q;
    assign hex_export   = r_hex_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_hex_display.sv
//------------------------------------------------------------------------------
// Module  : tb_multi_hex_display
// Brief   : Directed self-checking bench for multi_hex_display (6 digits,
//           blink divider 4).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_hex_display;

    localparam int c_nd = 6;

    logic              clk;
    logic              rst;
    logic [3:0]        avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic [7*c_nd-1:0] hex_export;

    int checks   = 0;
    int failures = 0;

    logic [31:0]       rd;
    logic [7*c_nd-1:0] pat;

    multi_hex_display #(
        .NUM_DIGITS (c_nd),
        .BLINK_DIV  (4)
    ) u_dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .hex_export    (hex_export)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    initial begin
        rst           = 1'b1;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_hex", hex_export, 42'h3FF_FFFF_FFFF);
        bus_read(4'd9, rd);  check("rst_blank", rd, 32'h3F);
        bus_read(4'd8, rd);  check("rst_ctrl", rd, 32'h0);
        bus_read(4'd0, rd);  check("rst_digit0", rd, 32'h0);

        // Packed write must also clear the upper bits of an earlier raw value.
        bus_write(4'd9, 32'h0);
        bus_write(4'd1, 32'h7F);
        bus_write(4'd10, 32'h0000_A81F);
        check("packed_hex", hex_export, {7'h40, 7'h40, 7'h08, 7'h00, 7'h79, 7'h0E});
        bus_read(4'd1, rd);  check("packed_digit1", rd, 32'h1);
        bus_read(4'd3, rd);  check("packed_digit3", rd, 32'hA);
        bus_read(4'd10, rd); check("packed_read0", rd, 32'h0);

        bus_write(4'd8, 32'h1);
        check("raw_digit0", hex_export[6:0], 7'h70);
        check("raw_digit2_pre", hex_export[20:14], 7'h77);
        bus_write(4'd2, 32'h7F);
        check("raw_digit2", hex_export[20:14], 7'h00);
        bus_write(4'd7, 32'h55);
        bus_read(4'd7, rd);  check("digit7_ignored", rd, 32'h0);
        bus_write(4'd6, 32'h33);
        bus_read(4'd6, rd);  check("digit6_ignored", rd, 32'h0);
        bus_write(4'd12, 32'hFFFF_FFFF);
        bus_read(4'd12, rd); check("addr12_read0", rd, 32'h0);
        bus_read(4'd2, rd);  check("digit2_read", rd, 32'h7F);

        bus_write(4'd9, 32'h02);
        check("blank_digit1", hex_export[13:7], 7'h7F);
        check("blank_digit0_kept", hex_export[6:0], 7'h70);
        bus_write(4'd9, 32'h0);
        bus_write(4'd8, 32'h0);

        pat = {7'h40, 7'h40, 7'h08, 7'h0E, 7'h79, 7'h0E};
        check("hex_pattern", hex_export, pat);

        // Phase rises four cycles after CTRL.blink_en is written.
        bus_write(4'd8, 32'h2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("blink_c%0d", k), hex_export, (k >= 4) ? 42'h3FF_FFFF_FFFF : pat);
        end
        bus_write(4'd8, 32'h0);
        check("blink_off_hex", hex_export, pat);
        bus_read(4'd11, rd); check("blink_off_status", rd, 32'h0);

        bus_write(4'd0, 32'h3);
        @(negedge clk);
        avs_address   = 4'd0;
        avs_writedata = 32'h5;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check("rw_old", avs_readdata, 32'h3);
        bus_read(4'd0, rd);  check("rw_new", rd, 32'h5);
        @(negedge clk);
        check("rdata_hold", avs_readdata, 32'h5);

        bus_write(4'd8, 32'h2);
        repeat (4) @(negedge clk);
        check("blink_again", hex_export, 42'h3FF_FFFF_FFFF);
        bus_read(4'd11, rd); check("status_phase1", rd, 32'h1);

        @(negedge clk);
        rst           = 1'b1;
        avs_address   = 4'd0;
        avs_writedata = 32'h9;
        avs_write     = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        avs_write = 1'b0;
        check("rst2_hex", hex_export, 42'h3FF_FFFF_FFFF);
        check("rst2_readdata", avs_readdata, 32'h0);
        bus_read(4'd0, rd);  check("rst2_digit0", rd, 32'h0);
        bus_read(4'd11, rd); check("rst2_status", rd, 32'h0);
        bus_read(4'd9, rd);  check("rst2_blank", rd, 32'h3F);
        bus_read(4'd8, rd);  check("rst2_ctrl", rd, 32'h0);
        repeat (5) @(negedge clk);
        check("rst2_no_blink", hex_export, 42'h3FF_FFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_hex_display.md
MULTI_HEX_DISPLAY -- requirements
Module: multi_hex_display

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of seven-segment digits driven; legal range 1..8.
REQ-002 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period; legal minimum 2.
REQ-003 clk_clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 reset_reset  in  1  synchronous, active-high reset.
REQ-005 avs_address  in  4  Avalon-MM word address.
REQ-006 avs_write  in  1  write strobe.
REQ-007 avs_writedata  in  32  write data.
REQ-008 avs_read  in  1  read strobe.
REQ-009 avs_readdata  out  32  read data, valid exactly 1 cycle after avs_read.
REQ-010 hex_export  out  7*NUM_DIGITS  active-low segments; digit i occupies bits [7i+6:7i], bit 0 = segment a, bit 6 = segment g.

Function
REQ-011 Register map: 0..NUM_DIGITS-1 DIGIT[i] (7 bits); 8 CTRL {bit1 blink_en, bit0 mode: 0=hex decode, 1=raw}; 9 BLANK mask [NUM_DIGITS-1:0]; 10 PACKED (write-only); 11 STATUS {bit0 blink_phase}.
REQ-012 Write to DIGIT[i] SHALL store writedata[6:0]; hex mode uses only bits [3:0].
REQ-013 Write to PACKED SHALL set DIGIT[i][3:0] = writedata[4i+3:4i] and DIGIT[i][6:4] = 0 for every i < NUM_DIGITS in the same cycle.
REQ-014 Writes to unmapped addresses, including DIGIT addresses >= NUM_DIGITS, SHALL be ignored; reads of them and of PACKED SHALL return 0.
REQ-015 Reads SHALL return zero-extended register contents one cycle after avs_read; with no read, avs_readdata SHALL hold its last value.
REQ-016 If avs_read and avs_write are both asserted, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-017 Hex mode: each digit SHALL show standard 0-F glyphs (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E); raw mode: segments = ~DIGIT[i].
REQ-018 A digit whose BLANK bit is 1 SHALL output 7'h7F.
REQ-019 Blink counter SHALL count 0..BLINK_DIV-1 while blink_en=1, toggling blink_phase on wrap to 0; when blink_en=0, counter and blink_phase SHALL be held at 0.
REQ-020 When blink_en=1 and blink_phase=1, every digit SHALL output 7'h7F, overriding mode and BLANK.
REQ-021 hex_export SHALL be registered: a register write or phase toggle in cycle N SHALL be visible in cycle N+1.
REQ-022 No wait states: every access SHALL complete in the cycle presented.

Reset
REQ-023 On reset: DIGIT[*]=0, CTRL=0, BLANK=all ones, counter=0, blink_phase=0, avs_readdata=0, hex_export=all ones (all segments off).
REQ-024 Reset asserted mid-blink or mid-access SHALL override all activity in that cycle; a write coincident with reset SHALL be discarded.

Structure
REQ-025 Shared package hex_disp_pkg SHALL hold register offsets, CTRL bit positions, mode enum (MODE_HEX, MODE_RAW) and the blank constant 7'h7F.
REQ-026 Glyph lookup SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out), instantiated NUM_DIGITS times.

Verification (NUM_DIGITS=6, BLINK_DIV=4)
REQ-027 Reset, then read BLANK -> readdata 0x3F; hex_export = 42'h3FF_FFFF_FFFF.
REQ-028 Write BLANK=0, PACKED=0x00A81F -> digits 0..5 = F,1,8,A,0,0; next cycle segment fields {7'h0E,7'h79,7'h00,7'h08,7'h40,7'h40}.
REQ-029 CTRL=1, DIGIT[2]=0x7F -> digit 2 field 7'h00; DIGIT[7] write ignored, read DIGIT[7] -> 0.
REQ-030 CTRL=2 -> blink_phase toggles every 4 cycles; all fields 7'h7F in phase 1; CTRL=0 mid-phase -> STATUS reads 0 and digits reappear next cycle.
REQ-031 Read and write DIGIT[0] same cycle, old=3, new=5 -> readdata 3, following read 5.
REQ-032 Assert reset during blink phase 1 with a coincident write -> all state per REQ-023, write lost.
